// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-port round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_MAX_BURST = 4;
    localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/two_port_bus_arbiter_if.sv
// Handshake bundle: two requesters, one registered output, and the mux select.
interface two_port_bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, sel
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, sel
    );
endinterface

// File: rtl/bus_arb_fsm.sv
// Grant FSM: round-robin between A and B with a bounded burst per grant.
module bus_arb_fsm
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_a_valid,
    input  logic   i_b_valid,
    input  logic   i_space,
    output state_e o_state,
    output logic   o_sel
);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_e           r_state, w_state_nxt, w_other;
    logic             r_last, w_last_nxt;
    logic             r_sel, w_sel_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_own_valid, w_oth_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= SEL_B;
            r_sel   <= SEL_A;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_own_valid = 1'b0;
        w_oth_valid = 1'b0;
        w_other     = IDLE;

        unique case (r_state)
            IDLE: begin
                if (i_a_valid && i_b_valid) begin
                    w_state_nxt = (r_last == SEL_B) ? GNT_A : GNT_B;
                end else if (i_a_valid) begin
                    w_state_nxt = GNT_A;
                end else if (i_b_valid) begin
                    w_state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                w_own_valid = i_a_valid;
                w_oth_valid = i_b_valid;
                w_other     = GNT_B;
            end
            GNT_B: begin
                w_own_valid = i_b_valid;
                w_oth_valid = i_a_valid;
                w_other     = GNT_A;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (r_state == GNT_A || r_state == GNT_B) begin
            if (!w_own_valid) begin
                w_state_nxt = w_oth_valid ? w_other : IDLE;
                w_cnt_nxt   = '0;
            end else if (i_space) begin
                // A transfer happens: ready equals space while granted.
                if (r_cnt == LAST_BEAT) begin
                    w_cnt_nxt = '0;
                    if (w_oth_valid) begin
                        w_state_nxt = w_other;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        if (w_state_nxt == GNT_A) begin
            w_last_nxt = SEL_A;
            w_sel_nxt  = SEL_A;
        end else if (w_state_nxt == GNT_B) begin
            w_last_nxt = SEL_B;
            w_sel_nxt  = SEL_B;
        end
    end

    assign o_state = r_state;
    assign o_sel   = r_sel;

endmodule

// File: rtl/two_port_bus_arbiter.sv
// Two-requester bus arbiter with a single-entry registered output stage.
module two_port_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    two_port_bus_arbiter_if.slave  io_bus
);
    state_e           w_state;
    logic             w_sel;
    logic             w_space;
    logic             w_a_ready, w_b_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    bus_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_a_valid (io_bus.a_valid),
        .i_b_valid (io_bus.b_valid),
        .i_space   (w_space),
        .o_state   (w_state),
        .o_sel     (w_sel)
    );

    assign w_space    = !r_out_valid || io_bus.out_ready;
    assign w_a_ready  = (w_state == GNT_A) && w_space;
    assign w_b_ready  = (w_state == GNT_B) && w_space;
    assign w_xfer     = (io_bus.a_valid && w_a_ready) || (io_bus.b_valid && w_b_ready);
    assign w_mux_data = (w_sel == SEL_B) ? io_bus.b_data : io_bus.a_data;

    // Load and drain in the same cycle simply reloads: no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.a_ready   = w_a_ready;
    assign io_bus.b_ready   = w_b_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.sel       = w_sel;

endmodule

// File: tb/tb_two_port_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_two_port_bus_arbiter;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    two_port_bus_arbiter_if #(.WIDTH(WIDTH)) bif ();

    two_port_bus_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bif)
    );

    always #5 clk = ~clk;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B.
    int          m_owner;
    int          m_beats;
    bit          m_last_b;
    bit          m_sel;
    bit          m_ov;
    logic [31:0] m_od;

    function automatic void model_reset();
        m_owner  = 0;
        m_beats  = 0;
        m_last_b = 1'b1;
        m_sel    = 1'b0;
        m_ov     = 1'b0;
        m_od     = '0;
    endfunction

    function automatic void model_step();
        bit space, accepted, mine, other;
        int nxt;
        space    = !m_ov || bif.out_ready;
        accepted = space && ((m_owner == 1 && bif.a_valid) || (m_owner == 2 && bif.b_valid));
        if (accepted) begin
            m_od = (m_owner == 1) ? bif.a_data : bif.b_data;
            m_ov = 1'b1;
        end else if (bif.out_ready) begin
            m_ov = 1'b0;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (bif.a_valid && bif.b_valid) nxt = m_last_b ? 1 : 2;
            else if (bif.a_valid) nxt = 1;
            else if (bif.b_valid) nxt = 2;
        end else begin
            mine  = (m_owner == 1) ? bif.a_valid : bif.b_valid;
            other = (m_owner == 1) ? bif.b_valid : bif.a_valid;
            if (!mine) begin
                nxt     = other ? 3 - m_owner : 0;
                m_beats = 0;
            end else if (accepted) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_beats = 0;
                    if (other) nxt = 3 - m_owner;
                end
            end
        end
        m_owner = nxt;
        if (nxt != 0) begin
            m_last_b = (nxt == 2);
            m_sel    = (nxt == 2);
        end
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bif.a_valid   = 1'b0;
        bif.b_valid   = 1'b0;
        bif.a_data    = '0;
        bif.b_data    = '0;
        bif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.a_valid = 1'b1; bif.b_valid = 1'b1;
        bif.a_data = 32'h1111_0001; bif.b_data = 32'h2222_0002;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid got %b want 0", bif.out_valid); end
        checks++; if (bif.out_data !== 32'h0) begin errors++;
            $display("FAIL rst_out_data got %h want 0", bif.out_data); end
        checks++; if (bif.sel !== 1'b0) begin errors++;
            $display("FAIL rst_sel got %b want 0", bif.sel); end
        checks++; if (bif.a_ready !== 1'b0 || bif.b_ready !== 1'b0) begin errors++;
            $display("FAIL rst_readys got %b%b want 00", bif.a_ready, bif.b_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (bif.a_ready !== 1'b1 || bif.b_ready !== 1'b0) begin errors++;
            $display("FAIL rst_first_grant got %b%b want 10", bif.a_ready, bif.b_ready); end
        checks++; if (bif.sel !== 1'b0 || bif.out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_cycle1 got sel %b ov %b want 0 0", bif.sel, bif.out_valid); end
        step();
        checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'h1111_0001) begin errors++;
            $display("FAIL rst_cycle2 got %b %h want 1 11110001", bif.out_valid, bif.out_data); end
    endtask

    task automatic test_single();
        do_reset();
        bif.b_valid = 1'b1; bif.b_data = 32'h0000_0004;
        #1;
        checks++; if (bif.b_ready !== 1'b0) begin errors++;
            $display("FAIL single_idle_ready got %b want 0", bif.b_ready); end
        step();
        checks++; if (bif.sel !== 1'b1 || bif.b_ready !== 1'b1 || bif.a_ready !== 1'b0) begin
            errors++; $display("FAIL single_grant got sel %b rdy %b%b want 1 01",
                               bif.sel, bif.a_ready, bif.b_ready); end
        step();
        checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== 32'h4) begin errors++;
            $display("FAIL single_data got %b %h want 1 4", bif.out_valid, bif.out_data); end
        checks++; if (bif.a_ready !== 1'b0) begin errors++;
            $display("FAIL single_a_ready got %b want 0", bif.a_ready); end
    endtask

    task automatic test_round_robin();
        logic [31:0] prev;
        int side;
        do_reset();
        bif.a_valid = 1'b1; bif.b_valid = 1'b1;
        bif.a_data = 32'hA000_0000; bif.b_data = 32'hB000_0000;
        prev = '0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            side = ((cyc - 1) / MAX_BURST) % 2;
            step();
            if (cyc > 1) begin
                if (((cyc - 2) / MAX_BURST) % 2 == 0) bif.a_data = bif.a_data + 1;
                else bif.b_data = bif.b_data + 1;
            end
            #1;
            checks++; if (bif.a_ready !== (side == 0) || bif.b_ready !== (side == 1)
                          || bif.sel !== side[0]) begin errors++;
                $display("FAIL rr_grant cyc %0d got rdy %b%b sel %b want side %0d",
                         cyc, bif.a_ready, bif.b_ready, bif.sel, side); end
            if (cyc > 1) begin
                checks++; if (bif.out_data !== prev) begin errors++;
                    $display("FAIL rr_data cyc %0d got %h want %h", cyc, bif.out_data, prev); end
            end
            prev = (side == 0) ? bif.a_data : bif.b_data;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bif.a_valid = 1'b1; bif.b_valid = 1'b1;
        bif.a_data = 32'hC000_0000; bif.b_data = 32'hD000_0000;
        step();
        step(); bif.a_data = 32'hC000_0001;
        step(); bif.a_data = 32'hC000_0002; bif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1;
            checks++; if (bif.a_ready !== 1'b0 || bif.out_valid !== 1'b1
                          || bif.out_data !== 32'hC000_0001) begin errors++;
                $display("FAIL bp_hold %0d got rdy %b ov %b data %h want 0 1 c0000001",
                         i, bif.a_ready, bif.out_valid, bif.out_data); end
        end
        step(); bif.out_ready = 1'b1; #1;
        checks++; if (bif.a_ready !== 1'b1 || bif.out_data !== 32'hC000_0001) begin errors++;
            $display("FAIL bp_release got %b %h want 1 c0000001", bif.a_ready, bif.out_data); end
        step(); bif.a_data = 32'hC000_0003; #1;
        checks++; if (bif.a_ready !== 1'b1 || bif.out_data !== 32'hC000_0002) begin errors++;
            $display("FAIL bp_next got %b %h want 1 c0000002", bif.a_ready, bif.out_data); end
        step(); #1;
        checks++; if (bif.b_ready !== 1'b1 || bif.a_ready !== 1'b0 || bif.sel !== 1'b1
                      || bif.out_data !== 32'hC000_0003) begin errors++;
            $display("FAIL bp_switch got rdy %b%b sel %b data %h want 01 1 c0000003",
                     bif.a_ready, bif.b_ready, bif.sel, bif.out_data); end
    endtask

    task automatic test_early_release();
        do_reset();
        bif.a_valid = 1'b1; bif.b_valid = 1'b1;
        step();
        step();
        step(); bif.a_valid = 1'b0; #1;
        checks++; if (bif.b_ready !== 1'b0) begin errors++;
            $display("FAIL early_b_wait got %b want 0", bif.b_ready); end
        step();
        checks++; if (bif.b_ready !== 1'b1 || bif.a_ready !== 1'b0 || bif.sel !== 1'b1) begin
            errors++; $display("FAIL early_switch got rdy %b%b sel %b want 01 1",
                               bif.a_ready, bif.b_ready, bif.sel); end
        step(); bif.b_valid = 1'b0;
        step();
        checks++; if (bif.sel !== 1'b1 || bif.a_ready !== 1'b0 || bif.b_ready !== 1'b0) begin
            errors++; $display("FAIL early_idle got sel %b rdy %b%b want 1 00",
                               bif.sel, bif.a_ready, bif.b_ready); end
        bif.a_valid = 1'b1; bif.b_valid = 1'b1;
        step();
        checks++; if (bif.a_ready !== 1'b1 || bif.sel !== 1'b0) begin errors++;
            $display("FAIL early_tie got a_ready %b sel %b want 1 0", bif.a_ready, bif.sel); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bif.b_valid = 1'b1; bif.b_data = 32'hE000_0007;
        step();
        step();
        checks++; if (bif.out_valid !== 1'b1 || bif.sel !== 1'b1 || bif.b_ready !== 1'b1) begin
            errors++; $display("FAIL areset_pre got ov %b sel %b rdy %b want 1 1 1",
                               bif.out_valid, bif.sel, bif.b_ready); end
        #2; rst_n = 1'b0; #1;
        checks++; if (bif.out_valid !== 1'b0 || bif.sel !== 1'b0 || bif.b_ready !== 1'b0
                      || bif.out_data !== 32'h0) begin errors++;
            $display("FAIL areset_clear got ov %b sel %b rdy %b data %h want 0 0 0 0",
                     bif.out_valid, bif.sel, bif.b_ready, bif.out_data); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (bif.b_ready !== 1'b0) begin errors++;
            $display("FAIL areset_idle got %b want 0", bif.b_ready); end
        step();
        checks++; if (bif.b_ready !== 1'b1 || bif.sel !== 1'b1) begin errors++;
            $display("FAIL areset_regrant got rdy %b sel %b want 1 1", bif.b_ready, bif.sel); end
    endtask

    task automatic test_random();
        bit exp_a, exp_b;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            model_step();
            #1;
            bif.a_valid   = ($urandom_range(0, 3) != 0);
            bif.b_valid   = ($urandom_range(0, 3) != 0);
            bif.out_ready = ($urandom_range(0, 3) != 0);
            bif.a_data    = $urandom;
            bif.b_data    = $urandom;
            #1;
            exp_a = (m_owner == 1) && (!m_ov || bif.out_ready);
            exp_b = (m_owner == 2) && (!m_ov || bif.out_ready);
            checks++; if (bif.a_ready !== exp_a || bif.b_ready !== exp_b) begin errors++;
                $display("FAIL rand_ready cyc %0d got %b%b want %b%b",
                         cyc, bif.a_ready, bif.b_ready, exp_a, exp_b); end
            checks++; if (bif.out_valid !== m_ov || bif.out_data !== m_od) begin errors++;
                $display("FAIL rand_out cyc %0d got %b %h want %b %h",
                         cyc, bif.out_valid, bif.out_data, m_ov, m_od); end
            checks++; if (bif.sel !== m_sel) begin errors++;
                $display("FAIL rand_sel cyc %0d got %b want %b", cyc, bif.sel, m_sel); end
        end
    endtask

    initial begin
        bif.a_valid = 1'b0; bif.b_valid = 1'b0;
        bif.a_data = '0; bif.b_data = '0; bif.out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/two_port_bus_arbiter.md
# two_port_bus_arbiter

Shares one WIDTH-bit result bus between two requesters, A and B, and drives the select of the 2:1 bus mux in front of it. It uses a valid/ready handshake on both inputs and on the output. A registered single-entry output stage decouples the downstream consumer. Arbitration is round-robin with a bounded burst per grant, so neither requester can starve the other.

## Interface
- WIDTH, 32: data width of each requester and of the output bus.
- MAX_BURST, 4: maximum back-to-back accepted transfers per grant while the other side is waiting. Legal range is 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has data.
- a_data  in  WIDTH  requester A payload.
- a_ready  out  1  A's beat is accepted this cycle.
- b_valid  in  1  requester B has data.
- b_data  in  WIDTH  requester B payload.
- b_ready  out  1  B's beat is accepted this cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  output beat.
- out_ready  in  1  downstream accepts the output beat.
- sel  out  1  mux select. 0 = A, 1 = B. Registered; equals the current grant.

## Operation
- **FSM states:** IDLE, GNT_A, GNT_B. A `last` bit records the side most recently granted.
- **From IDLE:**
  - Only a_valid → GNT_A.
  - Only b_valid → GNT_B.
  - Both valid → grant the side that is not `last`.
  - Neither valid → stay in IDLE.
- **Accept condition:** `space = !out_valid || out_ready`.
  - In GNT_A: a_ready = space. b_ready = 0.
  - In GNT_B: the mirror of GNT_A.
  - In IDLE: both readys = 0.
- **Transfer:** occurs when x_valid && x_ready. On a transfer, out_data ← x_data, out_valid ← 1, and burst_cnt increments.
- **Output drain:** when out_ready && out_valid and there is no new transfer, out_valid ← 0.
- **Leaving GNT_x:**
  - x_valid low: go to GNT_other if other_valid, else IDLE. burst_cnt ← 0.
  - Transfer with burst_cnt == MAX_BURST−1: go to GNT_other if other_valid, else stay in GNT_x. burst_cnt ← 0 in both cases.
  - Otherwise: remain in GNT_x.
- **`last` update:** set on every entry into GNT_A or GNT_B.
- **sel:** 0 in GNT_A, 1 in GNT_B. Holds its previous value in IDLE.
- **Data:** never modified; a straight pass-through of the selected requester.

## Timing
- **Reset values:** state = IDLE, last = 1 (so A wins the first tie), sel = 0, burst_cnt = 0, out_valid = 0, out_data = 0, a_ready = b_ready = 0.
- **Arbitration latency:** valid asserted in cycle n in IDLE → grant (and x_ready) in cycle n+1 → out_valid in cycle n+2.
- **Grant switch:** one cycle, directly from GNT_A to GNT_B with no IDLE bubble. Throughput while both sides stream is 1 beat per cycle.
- **Back-pressure:** out_ready low with out_valid high forces x_ready low. Grant and burst_cnt hold. The output register must not be overwritten.
- **Simultaneous drain and accept:** out_ready && out_valid && a transfer in the same cycle reloads the register with no bubble.
- **Requester drops valid while granted:** the grant is released the next cycle. No beat is lost, because none was accepted.
- **MAX_BURST = 1:** strict alternation whenever both sides are valid.
- **Reset mid-burst:** all state returns to reset values immediately. A beat pending in the output register is discarded.

## Structure
- **Shared package `bus_arb_pkg`:**
  - state enum {IDLE, GNT_A, GNT_B}.
  - SEL_A = 0, SEL_B = 1.
  - default WIDTH and MAX_BURST.
- **Sub-module `bus_arb_fsm`:** holds state, last and burst_cnt. Outputs the grant and sel.
- **Top level:** holds the output register, the readys and the data mux.

## Test plan
- **Reset behaviour:** hold rst_n low with a_valid = b_valid = 1 → all outputs at reset values. Release reset → grant A in cycle 1. out_data = a_data, out_valid in cycle 2.
- **Single requester:** b_valid only, b_data = 32'h0000_0004, out_ready = 1 → sel = 1. out_data = 4 two cycles after valid. a_ready stays 0.
- **Round-robin bursts:** both valid continuously, MAX_BURST = 4, out_ready = 1 → accepted sequence A,A,A,A,B,B,B,B,A… and sel toggles every 4 beats.
- **Back-pressure:** out_ready = 0 for 5 cycles while A is streaming → out_data holds the first beat. a_ready = 0, burst_cnt frozen. Release → next beat the following cycle with no loss or duplication.
- **Early release:** A drops valid after 2 beats while B is valid → GNT_B the next cycle and b_ready = 1. The next tie goes to A.
- **Async reset mid-transfer:** assert rst_n low between clock edges during a burst → out_valid, sel and the readys clear immediately. After release, arbitration restarts from IDLE.
